// File: rtl/wr_sim_uart_beacon.sv
// Simulation UART beacon: sends periodic or on-demand status frames as 8N1 serial bytes.
// Define WR_BEACON_PARITY_EN to switch to 8E1 framing (even parity bit after the data bits).
module wr_sim_uart_beacon #(
  parameter int g_node_id   = 1,
  parameter int g_clk_div   = 1085,
  parameter int g_period    = 125000,
  parameter int g_seq_bytes = 2
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic                     trig_i,
  input  logic [7:0]               status_i,
  output logic                     uart_txd_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [8*g_seq_bytes-1:0] seq_o
);

  localparam int SEQ_W   = 8 * g_seq_bytes;
  localparam int N_BYTES = 4 + g_seq_bytes;
  localparam int FRM_W   = 8 * N_BYTES;
  localparam int DIV_W   = $clog2(g_clk_div);
  localparam int TMR_W   = $clog2(g_period);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(g_clk_div - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(g_period - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);
  localparam logic [2:0]       BYTE_LAST = 3'(N_BYTES - 1);
  localparam logic [7:0]       NODE_ID   = 8'(g_node_id);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef WR_BEACON_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_even(input logic [7:0] b);
    return ^b;
  endfunction

  // Whole frame packed byte 0 at the LSB; the sequence number is byte-swapped so it goes out MSB-first.
  function automatic logic [FRM_W-1:0] build_frame(input logic [7:0] st, input logic [SEQ_W-1:0] sq);
    logic [7:0]       cks;
    logic [SEQ_W-1:0] sq_sw;
    cks   = 8'h55 ^ NODE_ID ^ st;
    sq_sw = '0;
    for (int i = 0; i < g_seq_bytes; i++) begin
      cks                = cks ^ sq[8*i +: 8];
      sq_sw[8*i +: 8]    = sq[8*(g_seq_bytes-1-i) +: 8];
    end
    return {cks, sq_sw, st, NODE_ID, 8'h55};
  endfunction

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [2:0]         bit_r, bit_s;
  logic [2:0]         byte_r, byte_s;
  logic [FRM_W-1:0]   frame_r, frame_s;
  logic [TMR_W-1:0]   tmr_r, tmr_s;
  logic               pend_r, pend_s;
  logic               txd_r, txd_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [SEQ_W-1:0]   seq_r, seq_s;
  logic [SEQ_W-1:0]   seq_inc_s;
  logic               bit_end_s;
  logic               wrap_s;
  logic               start_s;

  // Periodic request timer, held at zero while disabled
  always_comb begin
    tmr_s  = tmr_r;
    wrap_s = 1'b0;
    if (!en_i) begin
      tmr_s = '0;
    end else if (tmr_r == TMR_LAST) begin
      tmr_s  = '0;
      wrap_s = 1'b1;
    end else begin
      tmr_s = tmr_r + TMR_ONE;
    end
  end

  // Single-entry request flag; a new request in the start cycle re-arms it
  always_comb begin
    pend_s = (pend_r & ~start_s) | trig_i | wrap_s;
  end

  // Serialiser next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    bit_s     = bit_r;
    byte_s    = byte_r;
    frame_s   = frame_r;
    txd_s     = txd_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    seq_s     = seq_r;
    start_s   = 1'b0;
    seq_inc_s = seq_r + SEQ_ONE;
    bit_end_s = (div_r == DIV_LAST);

    if (state_r == ST_IDLE) begin
      div_s = '0;
    end else if (bit_end_s) begin
      div_s = '0;
    end else begin
      div_s = div_r + DIV_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        if (pend_r) begin
          start_s = 1'b1;
          state_s = ST_START;
          byte_s  = 3'd0;
          frame_s = build_frame(status_i, seq_r);
          txd_s   = 1'b0;
          busy_s  = 1'b1;
        end else begin
          txd_s  = 1'b1;
          busy_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          bit_s   = 3'd0;
          txd_s   = frame_r[0];
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_r == 3'd7)) begin
`ifdef WR_BEACON_PARITY_EN
          state_s = ST_PARITY;
          txd_s   = parity_even(frame_r[7:0]);
`else
          state_s = ST_STOP;
          txd_s   = 1'b1;
`endif
        end else if (bit_end_s) begin
          bit_s = bit_r + 3'd1;
          txd_s = frame_r[bit_r + 3'd1];
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef WR_BEACON_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          txd_s   = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s && (byte_r == BYTE_LAST)) begin
          done_s = 1'b1;
          seq_s  = seq_inc_s;
          // A queued request chains straight into the next start bit
          if (pend_r) begin
            start_s = 1'b1;
            state_s = ST_START;
            byte_s  = 3'd0;
            frame_s = build_frame(status_i, seq_inc_s);
            txd_s   = 1'b0;
          end else begin
            state_s = ST_IDLE;
            txd_s   = 1'b1;
            busy_s  = 1'b0;
          end
        end else if (bit_end_s) begin
          state_s = ST_START;
          byte_s  = byte_r + 3'd1;
          frame_s = frame_r >> 4'd8;
          txd_s   = 1'b0;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        txd_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      div_r   <= '0;
      bit_r   <= 3'd0;
      byte_r  <= 3'd0;
      frame_r <= '0;
      tmr_r   <= '0;
      pend_r  <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      seq_r   <= '0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      byte_r  <= byte_s;
      frame_r <= frame_s;
      tmr_r   <= tmr_s;
      pend_r  <= pend_s;
      txd_r   <= txd_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      seq_r   <= seq_s;
    end
  end

  assign uart_txd_o   = txd_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;
  assign seq_o        = seq_r;

endmodule

// File: tb/tb_wr_sim_uart_beacon.sv
// Directed bench for wr_sim_uart_beacon: decodes the serial frames and checks framing,
// timing, sequencing and reset behaviour on two differently parametrised instances.
`timescale 1ns/1ps
module tb_wr_sim_uart_beacon;

`ifdef WR_BEACON_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME1 = 6 * BITS * 4;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst1_n = 1'b0, en1 = 1'b0, trig1 = 1'b0;
  logic [7:0]  status1 = 8'h00;
  logic        txd1, busy1, done1;
  logic [15:0] seq1;

  logic        rst2_n = 1'b0, en2 = 1'b0, trig2 = 1'b0;
  logic [7:0]  status2 = 8'h00;
  logic        txd2, busy2, done2;
  logic [7:0]  seq2;

  int checks = 0;
  int errors = 0;

  wr_sim_uart_beacon #(.g_node_id(1), .g_clk_div(4), .g_period(1000), .g_seq_bytes(2)) dut1 (
    .clk_sys_i(clk), .rst_n_i(rst1_n), .en_i(en1), .trig_i(trig1), .status_i(status1),
    .uart_txd_o(txd1), .busy_o(busy1), .frame_done_o(done1), .seq_o(seq1));

  wr_sim_uart_beacon #(.g_node_id(8'hC3), .g_clk_div(2), .g_period(50), .g_seq_bytes(1)) dut2 (
    .clk_sys_i(clk), .rst_n_i(rst2_n), .en_i(en2), .trig_i(trig2), .status_i(status2),
    .uart_txd_o(txd2), .busy_o(busy2), .frame_done_o(done2), .seq_o(seq2));

  int busy_cnt1 = 0, done_cnt1 = 0, done_cnt2 = 0;
  always @(negedge clk) begin
    if (busy1) busy_cnt1 <= busy_cnt1 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (done2) done_cnt2 <= done_cnt2 + 1;
  end

  function automatic logic txd_of(input int inst);
    return (inst == 2) ? txd2 : txd1;
  endfunction

  // Waits (bounded) for a start bit, then samples each bit at its middle.
  task automatic rx_byte(input int inst, output logic [7:0] b, output logic p, output logic ok, output int t0);
    int   d;
    logic found;
    d = (inst == 2) ? 2 : 4;
    b = 8'h00; p = 1'b0; ok = 1'b0; t0 = -1; found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (txd_of(inst) == 1'b0) found = 1'b1;
    end
    if (found) begin
      t0 = cyc;
      ok = 1'b1;
      repeat (d / 2) @(negedge clk);
      if (txd_of(inst) !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (d) @(negedge clk);
        b[i] = txd_of(inst);
      end
`ifdef WR_BEACON_PARITY_EN
      repeat (d) @(negedge clk);
      p = txd_of(inst);
`endif
      repeat (d) @(negedge clk);
      if (txd_of(inst) !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic rx_frame(input int inst, input int nb, output logic [63:0] fr, output logic [7:0] par,
                          output logic ok, output int t0);
    logic [7:0] b;
    logic       p, bok;
    int         t;
    fr = '0; par = '0; ok = 1'b1; t0 = -1;
    for (int i = 0; i < nb; i++) begin
      rx_byte(inst, b, p, bok, t);
      fr[8*i +: 8] = b;
      par[i] = p;
      if (!bok) ok = 1'b0;
      if (i == 0) t0 = t;
    end
  endtask

  task automatic do_reset1();
    en1 = 1'b0; trig1 = 1'b0;
    @(negedge clk); rst1_n = 1'b0;
    repeat (3) @(negedge clk); rst1_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_trig1(output int c);
    @(negedge clk); trig1 = 1'b1; c = cyc;
    @(negedge clk); trig1 = 1'b0;
  endtask

  task automatic test_reset();
    rst1_n = 1'b0; rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd1 !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done1); end
    checks++; if (seq1 !== 16'h0000) begin errors++; $display("FAIL reset_seq: got %h want 0000", seq1); end
    rst1_n = 1'b1; rst2_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (txd1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: txd %b busy %b want 1 0", txd1, busy1); end
  endtask

  task automatic test_single_frame();
    logic [63:0] fr; logic [7:0] par; logic ok; int t0, c, b0, d0;
    do_reset1();
    status1 = 8'hA5; b0 = busy_cnt1; d0 = done_cnt1;
    pulse_trig1(c);
    rx_frame(1, 6, fr, par, ok, t0);
    repeat (8) @(negedge clk);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_framing: got %b want 1", ok); end
    checks++; if (fr[47:0] !== {8'hF1, 8'h00, 8'h00, 8'hA5, 8'h01, 8'h55}) begin
      errors++; $display("FAIL t1_bytes: got %h want f10000a50155", fr[47:0]); end
    checks++; if (t0 !== c + 2) begin errors++; $display("FAIL t1_latency: got %0d want %0d", t0, c + 2); end
    checks++; if (busy_cnt1 - b0 !== FRAME1) begin
      errors++; $display("FAIL t1_busy_len: got %0d want %0d", busy_cnt1 - b0, FRAME1); end
    checks++; if (done_cnt1 - d0 !== 1) begin errors++; $display("FAIL t1_done: got %0d want 1", done_cnt1 - d0); end
    checks++; if (seq1 !== 16'h0001) begin errors++; $display("FAIL t1_seq: got %h want 0001", seq1); end
  endtask

  task automatic test_periodic();
    logic [63:0] fr [3]; logic [7:0] par; logic ok [3]; int ts [3]; int e, d0;
    logic [7:0] cks;
    do_reset1();
    status1 = 8'h3C; d0 = done_cnt1; e = 0;
    fork
      begin
        @(negedge clk); en1 = 1'b1; e = cyc;
        repeat (3000) @(posedge clk);
        #1 en1 = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) rx_frame(1, 6, fr[k], par, ok[k], ts[k]);
      end
    join
    for (int k = 0; k < 3; k++) begin
      cks = 8'h68 ^ 8'(k);
      checks++; if (ok[k] !== 1'b1 || fr[k][47:0] !== {cks, 8'(k), 8'h00, 8'h3C, 8'h01, 8'h55}) begin
        errors++; $display("FAIL t2_frame%0d: got %h ok %b want %h", k, fr[k][47:0], ok[k],
                           {cks, 8'(k), 8'h00, 8'h3C, 8'h01, 8'h55}); end
    end
    checks++; if (ts[0] !== e + 1001) begin errors++; $display("FAIL t2_first_start: got %0d want %0d", ts[0], e + 1001); end
    checks++; if (ts[1] - ts[0] !== 1000 || ts[2] - ts[1] !== 1000) begin
      errors++; $display("FAIL t2_spacing: got %0d %0d want 1000 1000", ts[1] - ts[0], ts[2] - ts[1]); end
    repeat (2500) @(negedge clk);
    checks++; if (done_cnt1 - d0 !== 3) begin errors++; $display("FAIL t2_frame_count: got %0d want 3", done_cnt1 - d0); end
    checks++; if (seq1 !== 16'h0003) begin errors++; $display("FAIL t2_seq: got %h want 0003", seq1); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fa, fb; logic [7:0] par; logic oka, okb; int ta, tb, b0, d0;
    do_reset1();
    status1 = 8'h81; b0 = busy_cnt1; d0 = done_cnt1;
    fork
      begin
        @(negedge clk); trig1 = 1'b1;
        repeat (200) @(negedge clk);
        trig1 = 1'b0;
      end
      begin
        rx_frame(1, 6, fa, par, oka, ta);
        rx_frame(1, 6, fb, par, okb, tb);
      end
    join
    checks++; if (oka !== 1'b1 || fa[47:0] !== {8'hD5, 8'h00, 8'h00, 8'h81, 8'h01, 8'h55}) begin
      errors++; $display("FAIL t3_frame0: got %h ok %b want d50000810155", fa[47:0], oka); end
    checks++; if (okb !== 1'b1 || fb[47:0] !== {8'hD4, 8'h01, 8'h00, 8'h81, 8'h01, 8'h55}) begin
      errors++; $display("FAIL t3_frame1: got %h ok %b want d40100810155", fb[47:0], okb); end
    checks++; if (tb - ta !== FRAME1) begin errors++; $display("FAIL t3_no_gap: got %0d want %0d", tb - ta, FRAME1); end
    repeat (600) @(negedge clk);
    checks++; if (done_cnt1 - d0 !== 2) begin errors++; $display("FAIL t3_frame_count: got %0d want 2", done_cnt1 - d0); end
    checks++; if (busy_cnt1 - b0 !== 2 * FRAME1) begin
      errors++; $display("FAIL t3_busy_len: got %0d want %0d", busy_cnt1 - b0, 2 * FRAME1); end
  endtask

  task automatic test_seq_wrap();
    logic [63:0] fr; logic [7:0] par; logic ok, hit; int t0, d0;
    @(negedge clk); rst2_n = 1'b0;
    repeat (3) @(negedge clk); rst2_n = 1'b1;
    status2 = 8'h5A; trig2 = 1'b1; hit = 1'b0;
    for (int n = 0; n < 30000 && !hit; n++) begin
      @(posedge clk); #1;
      if (seq2 == 8'hFE) hit = 1'b1;
    end
    trig2 = 1'b0;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL t4_reach_fe: got seq %h want fe", seq2); end
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      if (seq2 == 8'hFF) hit = 1'b1;
    end
    rx_frame(2, 5, fr, par, ok, t0);
    d0 = done_cnt2;
    checks++; if (ok !== 1'b1 || fr[39:0] !== {8'h33, 8'hFF, 8'h5A, 8'hC3, 8'h55}) begin
      errors++; $display("FAIL t4_frame_ff: got %h ok %b want 33ff5ac355", fr[39:0], ok); end
    repeat (300) @(negedge clk);
    checks++; if (seq2 !== 8'h00) begin errors++; $display("FAIL t4_seq_wrap: got %h want 00", seq2); end
    checks++; if (done_cnt2 - d0 !== 1 || busy2 !== 1'b0) begin
      errors++; $display("FAIL t4_stop: done %0d busy %b want 1 0", done_cnt2 - d0, busy2); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] fr; logic [7:0] par; logic ok; int t0, c, d0;
    do_reset1();
    status1 = 8'h11;
    pulse_trig1(c);
    rx_frame(1, 6, fr, par, ok, t0);
    repeat (8) @(negedge clk);
    checks++; if (seq1 !== 16'h0001) begin errors++; $display("FAIL t5_pre_seq: got %h want 0001", seq1); end
    d0 = done_cnt1;
    pulse_trig1(c);
    repeat (17) @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL t5_mid_busy: got %b want 1", busy1); end
    rst1_n = 1'b0;
    #1;
    checks++; if (txd1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL t5_async: txd %b busy %b want 1 0", txd1, busy1); end
    checks++; if (seq1 !== 16'h0000) begin errors++; $display("FAIL t5_seq: got %h want 0000", seq1); end
    repeat (3) @(negedge clk); rst1_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (done_cnt1 - d0 !== 0) begin errors++; $display("FAIL t5_abandoned: got %0d want 0", done_cnt1 - d0); end
    pulse_trig1(c);
    rx_frame(1, 6, fr, par, ok, t0);
    repeat (8) @(negedge clk);
    checks++; if (ok !== 1'b1 || fr[47:0] !== {8'h45, 8'h00, 8'h00, 8'h11, 8'h01, 8'h55}) begin
      errors++; $display("FAIL t5_clean: got %h ok %b want 450000110155", fr[47:0], ok); end
    checks++; if (seq1 !== 16'h0001) begin errors++; $display("FAIL t5_post_seq: got %h want 0001", seq1); end
  endtask

  task automatic test_status07();
    logic [63:0] fr; logic [7:0] par; logic ok; int t0, c, b0;
    do_reset1();
    status1 = 8'h07; b0 = busy_cnt1;
    pulse_trig1(c);
    rx_frame(1, 6, fr, par, ok, t0);
    repeat (8) @(negedge clk);
    checks++; if (ok !== 1'b1 || fr[47:0] !== {8'h53, 8'h00, 8'h00, 8'h07, 8'h01, 8'h55}) begin
      errors++; $display("FAIL t6_bytes: got %h ok %b want 530000070155", fr[47:0], ok); end
    checks++; if (busy_cnt1 - b0 !== FRAME1) begin
      errors++; $display("FAIL t6_busy_len: got %0d want %0d", busy_cnt1 - b0, FRAME1); end
`ifdef WR_BEACON_PARITY_EN
    checks++; if (par[5:0] !== 6'b000110) begin
      errors++; $display("FAIL t6_parity: got %b want 000110", par[5:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_periodic();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid();
    test_status07();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
